// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with condition codes plus a 16-cycle shift-add
// multiplier that stalls upstream while it runs.
module exec_stage #(
    parameter int CTRL_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs,
    input  logic [15:0]       rd_data,
    input  logic [15:0]       rs_data,
    input  logic [15:0]       imm,
    input  logic [4:0]        shmnt,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [15:0]       result,
    output logic [15:0]       result_hi,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [2:0]        rd_out,
    output logic [2:0]        ccr
);
    localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,  OP_OR   = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5,  OP_SHL = 5'd6,  OP_SHR = 5'd7,  OP_INC  = 5'd8;
    localparam logic [4:0] OP_DEC = 5'd9,  OP_MUL = 5'd10, OP_SETC = 5'd11, OP_CLRC = 5'd12;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        rd;
        logic [15:0]       mcand;
    } mul_req_t;

    state_t      state_q, state_d;
    mul_req_t    mreq;
    logic [31:0] prod;
    logic [3:0]  cnt;

    logic [4:0]  alu_op;
    logic        use_imm, set_flags, accept;
    logic [15:0] op_a, op_b, alu_res;
    logic        c_new;
    logic [2:0]  ccr_d;
    logic [4:0]  shl_idx, shr_idx;
    logic [16:0] sum17, step_sum;

    // rs is carried for hazard logic elsewhere; this stage does not need it
    logic unused_rs;
    assign unused_rs = ^rs;

    assign alu_op    = ctrl[4:0];
    assign use_imm   = ctrl[5];
    assign set_flags = ctrl[6];
    assign op_a      = rd_data;
    assign op_b      = use_imm ? imm : rs_data;
    assign stall     = (state_q != IDLE);
    assign accept    = in_valid && !stall && !flush;
    assign shl_idx   = 5'd16 - shmnt;
    assign shr_idx   = shmnt - 5'd1;

    always_comb begin
        alu_res = op_a;
        c_new   = ccr[2];
        sum17   = 17'd0;
        case (alu_op)
            OP_ADD: begin
                sum17   = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum17[15:0];
                c_new   = sum17[16];
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                c_new   = (op_a < op_b);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin
                if (shmnt >= 5'd16) begin
                    alu_res = 16'd0;
                    c_new   = 1'b0;
                end else if (shmnt != 5'd0) begin
                    alu_res = op_a << shmnt;
                    c_new   = op_a[shl_idx[3:0]];
                end
            end
            OP_SHR: begin
                if (shmnt >= 5'd16) begin
                    alu_res = 16'd0;
                    c_new   = 1'b0;
                end else if (shmnt != 5'd0) begin
                    alu_res = op_a >> shmnt;
                    c_new   = op_a[shr_idx[3:0]];
                end
            end
            OP_INC: begin
                alu_res = op_a + 16'd1;
                c_new   = (op_a == 16'hFFFF);
            end
            OP_DEC: begin
                alu_res = op_a - 16'd1;
                c_new   = (op_a == 16'h0000);
            end
            OP_SETC: c_new = 1'b1;
            OP_CLRC: c_new = 1'b0;
            default: ;
        endcase
    end

    // SETC/CLRC touch C even when the instruction does not ask for flags
    always_comb begin
        ccr_d = ccr;
        if (set_flags)
            ccr_d = {c_new, alu_res[15], (alu_res == 16'h0000)};
        else if (alu_op == OP_SETC || alu_op == OP_CLRC)
            ccr_d[2] = c_new;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && alu_op == OP_MUL) state_d = MUL;
            MUL:     if (cnt == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // One shift-add step: add multiplicand into the high half when the LSB is set, then shift right
    assign step_sum = {1'b0, prod[31:16]} + (prod[0] ? {1'b0, mreq.mcand} : 17'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            ctrl_out  <= '0;
            rd_out    <= '0;
            ccr       <= '0;
            mreq      <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (!flush) begin
                case (state_q)
                    IDLE: if (accept) begin
                        if (alu_op == OP_MUL) begin
                            mreq <= '{ctrl: ctrl, rd: rd, mcand: op_a};
                            prod <= {16'd0, op_b};
                            cnt  <= 4'd0;
                        end else begin
                            result    <= alu_res;
                            result_hi <= 16'd0;
                            ctrl_out  <= ctrl;
                            rd_out    <= rd;
                            ccr       <= ccr_d;
                            out_valid <= 1'b1;
                        end
                    end
                    MUL: begin
                        prod <= {step_sum, prod[15:1]};
                        cnt  <= cnt + 4'd1;
                    end
                    DONE: begin
                        result    <= prod[15:0];
                        result_hi <= prod[31:16];
                        ctrl_out  <= mreq.ctrl;
                        rd_out    <= mreq.rd;
                        out_valid <= 1'b1;
                        if (mreq.ctrl[6])
                            ccr <= {ccr[2], prod[31], (prod == 32'd0)};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: a reference model pushes expected results to a
// scoreboard at issue time; a negedge monitor pops and compares on out_valid.
module tb_exec_stage;
    localparam int CTRL_W = 30;
    localparam logic [4:0] PASS = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, NOT_ = 5, SHL = 6, SHR = 7;
    localparam logic [4:0] INC = 8, DEC = 9, MULOP = 10, SETC = 11, CLRC = 12;

    logic              clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, flush = 1'b0;
    logic [CTRL_W-1:0] ctrl = '0;
    logic [2:0]        rd = '0, rs = '0;
    logic [15:0]       rd_data = '0, rs_data = '0, imm = '0;
    logic [4:0]        shmnt = '0;
    logic              stall, out_valid;
    logic [15:0]       result, result_hi;
    logic [CTRL_W-1:0] ctrl_out;
    logic [2:0]        rd_out, ccr;

    exec_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ctrl(ctrl), .rd(rd), .rs(rs),
        .rd_data(rd_data), .rs_data(rs_data), .imm(imm), .shmnt(shmnt), .flush(flush),
        .stall(stall), .out_valid(out_valid), .result(result), .result_hi(result_hi),
        .ctrl_out(ctrl_out), .rd_out(rd_out), .ccr(ccr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]       res;
        logic [15:0]       hi;
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        rd;
        logic [2:0]        ccr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    logic [2:0]  m_ccr = '0;
    logic [15:0] last_res = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] sh, input logic sf, inout logic [2:0] cc,
                         output logic [15:0] r, output logic [15:0] h);
        logic        c;
        logic [16:0] w17;
        logic [31:0] w32;
        r = a; h = 16'd0; c = cc[2]; w32 = '0;
        case (op)
            ADD:  begin w17 = {1'b0, a} + {1'b0, b}; r = w17[15:0]; c = w17[16]; end
            SUB:  begin r = a - b; c = (a < b); end
            AND_: r = a & b;
            OR_:  r = a | b;
            NOT_: r = ~a;
            SHL:  if (sh >= 16) begin r = 0; c = 0; end
                  else if (sh != 0) begin w32 = {16'd0, a} << sh; r = w32[15:0]; c = w32[16]; end
            SHR:  if (sh >= 16) begin r = 0; c = 0; end
                  else if (sh != 0) begin w32 = {a, 16'd0} >> sh; r = w32[31:16]; c = w32[15]; end
            INC:  begin r = a + 16'd1; c = (a == 16'hFFFF); end
            DEC:  begin r = a - 16'd1; c = (a == 16'h0000); end
            MULOP: begin w32 = {16'd0, a} * {16'd0, b}; r = w32[15:0]; h = w32[31:16]; end
            SETC: c = 1'b1;
            CLRC: c = 1'b0;
            default: ;
        endcase
        if (op == MULOP) begin
            if (sf) cc = {cc[2], w32[31], (w32 == 32'd0)};
        end else if (sf) cc = {c, r[15], (r == 16'd0)};
        else if (op == SETC || op == CLRC) cc[2] = c;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ui, input logic sf, input logic [4:0] sh,
                         input logic [2:0] d, input logic [22:0] hib, input bit push);
        logic [15:0] r, h;
        in_valid = 1'b1;
        ctrl     = {hib, sf, ui, op};
        rd       = d;
        rs       = 3'($urandom);
        rd_data  = a;
        shmnt    = sh;
        if (ui) begin imm = b; rs_data = 16'($urandom); end
        else    begin rs_data = b; imm = 16'($urandom); end
        if (push) begin
            model(op, a, b, sh, sf, m_ccr, r, h);
            last_res = r;
            sb.push_back('{res: r, hi: h, ctrl: ctrl, rd: d, ccr: m_ccr});
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("sb_result", 64'(result), 64'(e.res));
                chk("sb_result_hi", 64'(result_hi), 64'(e.hi));
                chk("sb_ctrl_out", 64'(ctrl_out), 64'(e.ctrl));
                chk("sb_rd_out", 64'(rd_out), 64'(e.rd));
                chk("sb_ccr", 64'(ccr), 64'(e.ccr));
            end
        end
    end

    logic [4:0]  t_op [14] = '{AND_, OR_, NOT_, SHR, SHR, SHR, INC, DEC, SETC, CLRC, PASS, 5'd20, ADD, SHL};
    logic [15:0] t_a  [14] = '{16'hF0F0, 16'h0F00, 16'h00FF, 16'h8003, 16'h8003, 16'hFFFF,
                               16'hFFFF, 16'h0000, 16'h1234, 16'h8000, 16'h0000, 16'hABCD, 16'h7FFF, 16'h0001};
    logic [15:0] t_b  [14] = '{16'h3C3C, 16'h00F0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    logic [4:0]  t_sh [14] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd15};
    logic        t_sf [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_result_hi", 64'(result_hi), 64'd0);
        chk("rst_ctrl_out", 64'(ctrl_out), 64'd0);
        chk("rst_rd_out", 64'(rd_out), 64'd0);
        chk("rst_ccr", 64'(ccr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        drive(ADD, 16'hFFFF, 16'h0001, 1, 1, 0, 3'd2, 23'h5A5A5, 1); tick();
        chk("add_wrap_valid", 64'(out_valid), 64'd1);
        chk("add_wrap_result", 64'(result), 64'h0000);
        chk("add_wrap_ccr", 64'(ccr), 64'b101);

        drive(SUB, 16'h0003, 16'h0005, 0, 1, 0, 3'd3, 23'h0, 1); tick();
        chk("sub_result", 64'(result), 64'hFFFE);
        chk("sub_ccr", 64'(ccr), 64'b110);

        drive(SHL, 16'h8001, 16'h0, 0, 1, 5'd1, 3'd4, 23'h1, 1); tick();
        chk("shl1_result", 64'(result), 64'h0002);
        chk("shl1_c", 64'(ccr[2]), 64'd1);
        drive(SHL, 16'h8001, 16'h0, 0, 1, 5'd20, 3'd4, 23'h1, 1); tick();
        chk("shl20_result", 64'(result), 64'h0000);
        chk("shl20_c", 64'(ccr[2]), 64'd0);

        for (int i = 0; i < 14; i++) begin
            drive(t_op[i], t_a[i], t_b[i], i[0], t_sf[i], t_sh[i], 3'(i), 23'(i * 977), 1);
            tick();
        end

        // idle input: nothing written, outputs hold
        rd_data = 16'hDEAD; ctrl = '1; tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_result_hold", 64'(result), 64'(last_res));

        drive(ADD, 16'h0001, 16'h0001, 0, 1, 0, 3'd1, 23'h0, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_blocks_accept", 64'(out_valid), 64'd0);

        // MUL with in_valid held high; later inputs must be dropped
        drive(MULOP, 16'h1234, 16'h0100, 0, 1, 0, 3'd5, 23'h2AAAA, 1);
        @(posedge clk); #1;
        chk("mul_stall_start", 64'(stall), 64'd1);
        ctrl = {23'h0, 1'b1, 1'b0, ADD}; rd_data = 16'h0042;
        n = 1;
        while (stall === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            if (stall === 1'b1) n++;
        end
        in_valid = 1'b0;
        chk("mul_stall_cycles", 64'(n), 64'd17);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_result", 64'(result), 64'h3400);
        chk("mul_result_hi", 64'(result_hi), 64'h0012);
        tick();
        chk("mul_valid_pulse", 64'(out_valid), 64'd0);
        chk("mul_hi_hold", 64'(result_hi), 64'h0012);

        drive(MULOP, 16'h0000, 16'h0055, 0, 1, 0, 3'd6, 23'h3, 1); tick();
        n = 1;
        while (stall === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            if (stall === 1'b1) n++;
        end
        chk("mul0_stall_cycles", 64'(n), 64'd17);
        chk("mul0_valid", 64'(out_valid), 64'd1);
        chk("mul0_ccr", 64'(ccr), 64'(m_ccr));

        // flush at iteration 5 discards the MUL
        drive(MULOP, 16'hFFFF, 16'hFFFF, 0, 1, 0, 3'd7, 23'h0, 0); tick();
        repeat (4) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_ccr", 64'(ccr), 64'(m_ccr));
        drive(ADD, 16'h1000, 16'h2345, 0, 1, 0, 3'd2, 23'h7, 1); tick();
        chk("post_flush_add_valid", 64'(out_valid), 64'd1);
        chk("post_flush_add_result", 64'(result), 64'h3345);
        repeat (20) tick();

        // reset at iteration 8 aborts the MUL
        drive(MULOP, 16'h00FF, 16'h00FF, 0, 1, 0, 3'd3, 23'h9, 0); tick();
        repeat (7) tick();
        rst_n = 1'b0; #1;
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_outputs", 64'({result, result_hi, rd_out, ccr}), 64'd0);
        chk("arst_ctrl_out", 64'(ctrl_out), 64'd0);
        m_ccr = '0;
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        drive(ADD, 16'h0010, 16'h0020, 1, 1, 0, 3'd1, 23'h0, 1); tick();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", 64'(result), 64'h0030);
        chk("post_rst_stall", 64'(stall), 64'd0);

        repeat (3) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 30, giving the width of the control-signal bundle received from the decode/execute register.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the decode/execute register holds a real instruction.
REQ-005 The block SHALL have port ctrl, input, CTRL_W bits: the control bundle. [4:0] is alu_op, [5] is use_imm, [6] is set_flags, [7] is reg_write; the other bits pass through unchanged.
REQ-006 The block SHALL have ports rd and rs, input, 3 bits each: the register indices.
REQ-007 The block SHALL have ports rd_data and rs_data, input, 16 bits each: the operand values.
REQ-008 The block SHALL have port imm, input, 16 bits, and port shmnt, input, 5 bits.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-010 The block SHALL have port stall, output, 1 bit: the upstream stages must hold.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output bundle holds a valid result.
REQ-012 The block SHALL have ports result and result_hi, output, 16 bits each.
REQ-013 The block SHALL have ports ctrl_out (CTRL_W bits) and rd_out (3 bits), output: registered copies of ctrl and rd.
REQ-014 The block SHALL have port ccr, output, 3 bits: {C,N,Z}, with Z at bit 0, N at bit 1, C at bit 2.

Function
REQ-015 An input SHALL be accepted on a rising edge when in_valid=1, stall=0 and flush=0; in every other case the input is ignored.
REQ-016 Operands SHALL be A=rd_data and B=(use_imm ? imm : rs_data).
REQ-017 Single-cycle ops SHALL register result, ctrl_out and rd_out, with out_valid=1, on the accepting edge (latency 1).
REQ-018 alu_op encodings SHALL be as follows; all arithmetic is 16-bit modulo.
- 0 PASS: result=A.
- 1 ADD: A+B, C=carry out of bit 15.
- 2 SUB: A-B, C=1 iff A<B unsigned.
- 3 AND; 4 OR; 5 NOT: ~A.
- 6 SHL: A<<shmnt, C=last bit shifted out.
- 7 SHR: A>>shmnt logical, C=last bit shifted out.
- 8 INC: A+1, C=carry.
- 9 DEC: A-1, C=borrow.
- 10 MUL: unsigned, multi-cycle.
- 11 SETC: C=1. 12 CLRC: C=0.
- 13-31: treated as PASS.
REQ-019 For SHL and SHR with shmnt=0, result SHALL be A and C unchanged; with shmnt>=16, result SHALL be 0 and C=0.
REQ-020 When set_flags=1, Z and N SHALL be updated from the 16-bit result, and C per REQ-018 (C unchanged where REQ-018 gives none). When set_flags=0, ccr SHALL be unchanged. SETC and CLRC SHALL modify C regardless of set_flags.
REQ-021 For non-MUL ops, result_hi SHALL be 0.
REQ-022 The MUL state machine SHALL have states IDLE, MUL and DONE.
- IDLE->MUL on acceptance of alu_op=10; the operands and ctrl are latched and stall=1 from that edge.
- MUL performs one shift-add iteration per cycle for exactly 16 cycles.
- MUL->DONE after the 16th iteration.
- DONE->IDLE on the next edge, which writes result=product[15:0], result_hi=product[31:16] and out_valid=1, and clears stall.
- Accept edge to out_valid edge is 17 cycles.
- With set_flags=1, the MUL write SHALL set Z=(product==0) and N=product[31], with C unchanged.
REQ-023 stall SHALL equal (state != IDLE); in_valid while stall=1 SHALL be ignored, not queued.
REQ-024 out_valid SHALL be 0 on every edge that does not write a result; result, result_hi, rd_out and ctrl_out SHALL hold their last values.
REQ-025 flush=1 SHALL have priority over acceptance and over any in-progress MUL. On that edge:
- out_valid is cleared.
- The FSM returns to IDLE, so stall=0 next cycle.
- The MUL is discarded and ccr is unchanged.
REQ-026 A MUL accepted with an operand of 0 SHALL still take the full 17 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, including mid-MUL, with the MUL aborted:
- FSM to IDLE, stall=0, out_valid=0;
- result, result_hi, ctrl_out, rd_out and ccr to 0.
REQ-028 The first edge after rst_n rises SHALL be able to accept an input.

Verification
REQ-029 ADD with A=0xFFFF, B=imm=0x0001, use_imm=1, set_flags=1 -> next cycle result=0x0000, out_valid=1, ccr=3'b101.
REQ-030 SUB with A=0x0003, B=0x0005, set_flags=1 -> result=0xFFFE, ccr=3'b110.
REQ-031 SHL with A=0x8001, shmnt=1 -> result=0x0002, C=1; then SHL with shmnt=20 -> result=0, C=0.
REQ-032 MUL with A=0x1234, B=0x0100, with in_valid held high throughout:
- stall=1 for 17 cycles;
- then result=0x3400, result_hi=0x0012, out_valid=1 for one cycle;
- no other input is accepted during stall.
REQ-033 MUL accepted, flush at iteration 5 -> stall=0 and out_valid=0 next cycle, ccr unchanged, and the next ADD completes normally.
REQ-034 rst_n asserted at iteration 8 of a MUL -> all outputs 0 asynchronously; the first instruction after release completes with latency 1.
